// File: rtl/fifo_occ_pkg.sv
// Shared helpers for the occupancy-tracking FWFT FIFO.
//   clog2        : ceiling log2 for sizing checks
//   cnt_width    : width of the occupancy counter (one more bit than the pointers)
//   ptr_next     : pointer increment with explicit wrap at depth-1, so any depth works
//   params_legal : parameter-legality predicate evaluated at elaboration
package fifo_occ_pkg;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((longint'(1) << i) < longint'(value)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

  function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

  function automatic bit params_legal(input int unsigned depth, input int unsigned addr_width,
                                      input int unsigned grace);
    return (depth >= 2) && (grace < depth) && (clog2(depth) <= addr_width);
  endfunction

endpackage

// File: rtl/fifo_sdp_mem.sv
// Simple dual-port storage array: one write port, one registered read port.
// The read register reloads every cycle; a write to the address being read in the same cycle
// is forwarded, so the read register always mirrors the current contents at rd_addr.
// Ports:
//   clk      : clock
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write data
//   rd_addr  : read address (sampled every cycle)
//   rd_data  : registered read data
module fifo_sdp_mem #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DEPTH      = 32
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    // Write-first: the head prefetch must see a word written into the slot it is watching.
    if (wr_en && (wr_addr == rd_addr)) rd_data_q <= wr_data;
    else                               rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_fwft_occupancy.sv
// First-word-fall-through FIFO with almost-full backpressure (GRACE_PERIOD slots of slack),
// live occupancy count and almost-empty flag. Any DEPTH >= 2 is supported.
// The head word lives in a register (if_dout); the remaining count-1 words live in the array.
// Optional sticky error flags are built when FIFO_ERR_FLAGS_EN is defined.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   if_full_n         : producer may write (registered, almost-full semantics)
//   if_write_ce/write : write enable / request, if_din write data
//   if_empty_n        : if_dout holds a valid head
//   if_read_ce/read   : read enable / pop request
//   if_dout           : registered head data, held while empty
//   if_almost_empty_n : count > ALMOST_EMPTY_THRESH
//   if_count          : entries held, head included
//   if_overflow/if_underflow : sticky error flags (FIFO_ERR_FLAGS_EN only)
module fifo_fwft_occupancy
  import fifo_occ_pkg::*;
#(
  parameter int unsigned DATA_WIDTH          = 32,
  parameter int unsigned ADDR_WIDTH          = 5,
  parameter int unsigned DEPTH               = 32,
  parameter int unsigned GRACE_PERIOD        = 2,
  parameter int unsigned ALMOST_EMPTY_THRESH = 1,
  localparam int unsigned CNT_W              = cnt_width(ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  if_full_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_empty_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_almost_empty_n,
  output logic [CNT_W-1:0]      if_count
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                  if_overflow,
  output logic                  if_underflow
`endif
);

  if (!params_legal(DEPTH, ADDR_WIDTH, GRACE_PERIOD)) begin : gen_bad_params
    $error("fifo_fwft_occupancy: need 2 <= DEPTH <= 2**ADDR_WIDTH and GRACE_PERIOD < DEPTH");
  end

  logic [CNT_W-1:0]      count_q, count_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [DATA_WIDTH-1:0] head_q, head_d, mem_rd_data;
  logic                  full_n_q, empty_n_q, almost_empty_n_q;
  logic                  push, pop, at_cap, cnt_is_0, cnt_is_1;
  logic                  mem_push, mem_pop, head_from_din;

  assign cnt_is_0 = (count_q == '0);
  assign cnt_is_1 = (count_q == CNT_W'(1));
  assign at_cap   = (count_q == CNT_W'(DEPTH));
  assign pop      = if_read & if_read_ce & empty_n_q;
  assign push     = if_write & if_write_ce & (~at_cap | pop);

  // Pushed word bypasses the array when it will be the only word held afterwards.
  assign head_from_din = push & (cnt_is_0 | (cnt_is_1 & pop));
  assign mem_push      = push & ~head_from_din;
  // The array holds words only behind the head, i.e. when count >= 2.
  assign mem_pop       = pop & ~cnt_is_0 & ~cnt_is_1;

  always_comb begin
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    rd_ptr_d = mem_pop  ? ADDR_WIDTH'(ptr_next(32'(rd_ptr_q), DEPTH)) : rd_ptr_q;
    wr_ptr_d = mem_push ? ADDR_WIDTH'(ptr_next(32'(wr_ptr_q), DEPTH)) : wr_ptr_q;
    head_d   = head_q;
    if (head_from_din)  head_d = if_din;
    else if (mem_pop)   head_d = mem_rd_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q          <= '0;
      rd_ptr_q         <= '0;
      wr_ptr_q         <= '0;
      head_q           <= '0;
      full_n_q         <= 1'b1;
      empty_n_q        <= 1'b0;
      almost_empty_n_q <= 1'b0;
    end else begin
      count_q          <= count_d;
      rd_ptr_q         <= rd_ptr_d;
      wr_ptr_q         <= wr_ptr_d;
      head_q           <= head_d;
      full_n_q         <= (count_d < CNT_W'(DEPTH - GRACE_PERIOD));
      empty_n_q        <= (count_d != '0);
      almost_empty_n_q <= (count_d > CNT_W'(ALMOST_EMPTY_THRESH));
    end
  end

  // Read address is the next pointer so the registered read lands on the word at rd_ptr_q.
  fifo_sdp_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (mem_push & ~reset),
    .wr_addr (wr_ptr_q),
    .wr_data (if_din),
    .rd_addr (reset ? '0 : rd_ptr_d),
    .rd_data (mem_rd_data)
  );

  assign if_full_n         = full_n_q;
  assign if_empty_n        = empty_n_q;
  assign if_almost_empty_n = almost_empty_n_q;
  assign if_dout           = head_q;
  assign if_count          = count_q;

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_q | (if_write & if_write_ce & at_cap & ~pop);
      underflow_q <= underflow_q | (if_read & if_read_ce & ~empty_n_q);
    end
  end

  assign if_overflow  = overflow_q;
  assign if_underflow = underflow_q;
`endif

endmodule
